xeng_cmac: RTL and testbench

- Complex multiply-accumulate cell for the X-engine correlator.
- Each cycle it multiplies P_FACTOR complex sample pairs, a times conj(b), sums them, and accumulates 2^SERIAL_ACC_LEN_BITS consecutive results into a window aligned to sync.
- At window end it puts the result onto the X-engine accumulation shift chain (acc_in to acc_out). Otherwise it passes the chain data through.

---
 rtl/xeng_cmac.sv | 259 +++++++++++++++++++++++++
 tb/tb_xeng_cmac.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/xeng_cmac.sv
// xeng_cmac: complex multiply-accumulate cell for the X-engine correlator.
// Each cycle it forms sum_i a_i * conj(b_i) over P_FACTOR lanes. It accumulates
// 2^SERIAL_ACC_LEN_BITS consecutive sums into a window aligned to sync. At the
// end of each window it drops the total onto the acc_in -> acc_out shift chain.
// Optional feature: define CMAC_SYNC_OUT_EN to add a sync_out port, which is
// sync delayed to line up with acc_out.
module xeng_cmac #(
  parameter int BITWIDTH            = 4,
  parameter int P_FACTOR_BITS       = 0,
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int ACC_MUX_LATENCY     = 2,
  parameter int FIRST_DSP_REGISTERS = 2,
  parameter int DSP_REGISTERS       = 2,
  localparam int P_FACTOR      = 1 << P_FACTOR_BITS,
  localparam int MULT_LATENCY  = (P_FACTOR - 1) * DSP_REGISTERS + FIRST_DSP_REGISTERS + 2,
  localparam int MULT_BITS_OUT = 2 * BITWIDTH + 1 + P_FACTOR_BITS,
  localparam int ACC_BITS_OUT  = MULT_BITS_OUT + SERIAL_ACC_LEN_BITS,
  localparam int SAMPLE_BITS   = 2 * BITWIDTH * P_FACTOR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync,
  input  logic [SAMPLE_BITS-1:0]    a,
  input  logic [SAMPLE_BITS-1:0]    b,
  input  logic [2*ACC_BITS_OUT-1:0] acc_in,
  input  logic                      valid_in,
  output logic [2*ACC_BITS_OUT-1:0] acc_out,
  output logic                      valid_out
`ifdef CMAC_SYNC_OUT_EN
  ,
  output logic                      sync_out
`endif
);

  localparam int LANE_BITS  = 2 * BITWIDTH + 1;
  localparam int TAIL_DEPTH = (P_FACTOR - 1) * DSP_REGISTERS;

  // Pull one signed part out of a packed sample word and sign-extend it to lane width.
  function automatic logic signed [LANE_BITS-1:0] part(input logic [SAMPLE_BITS-1:0] x,
                                                       input int lane, input bit imag);
    logic signed [BITWIDTH-1:0] p;
    p = x[2*BITWIDTH*lane + (imag ? 0 : BITWIDTH) +: BITWIDTH];
    return LANE_BITS'(p);
  endfunction

  // ---------------------------------------------------------------------------
  // Window counter: phase of the sample currently on a/b
  // ---------------------------------------------------------------------------
  logic [SERIAL_ACC_LEN_BITS-1:0] win_cnt;

  // Window counter: restart on sync, otherwise free-run and wrap at N.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       win_cnt <= '0;
    else if (sync) win_cnt <= '0;
    else           win_cnt <= win_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Input register stages in front of the multipliers
  // ---------------------------------------------------------------------------
  logic [SAMPLE_BITS-1:0] a_mul, b_mul;

  generate
    if (FIRST_DSP_REGISTERS == 0) begin : g_no_in_reg
      assign a_mul = a;
      assign b_mul = b;
    end else begin : g_in_reg
      logic [SAMPLE_BITS-1:0] a_sr [FIRST_DSP_REGISTERS];
      logic [SAMPLE_BITS-1:0] b_sr [FIRST_DSP_REGISTERS];

      // Input delay line: a/b shift through the DSP input registers.
      // NOTE: pipeline arrays are reset as well, so the products that drain out
      // right after reset are zero and the first dump carries an exact 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < FIRST_DSP_REGISTERS; i++) begin
            a_sr[i] <= '0;
            b_sr[i] <= '0;
          end
        end else begin
          a_sr[0] <= a;
          b_sr[0] <= b;
          for (int i = 1; i < FIRST_DSP_REGISTERS; i++) begin
            a_sr[i] <= a_sr[i-1];
            b_sr[i] <= b_sr[i-1];
          end
        end
      end

      assign a_mul = a_sr[FIRST_DSP_REGISTERS-1];
      assign b_mul = b_sr[FIRST_DSP_REGISTERS-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-lane a * conj(b), then lane sum
  // ---------------------------------------------------------------------------
  logic signed [LANE_BITS-1:0]     lane_re_c [P_FACTOR];
  logic signed [LANE_BITS-1:0]     lane_im_c [P_FACTOR];
  logic signed [LANE_BITS-1:0]     lane_re_q [P_FACTOR];
  logic signed [LANE_BITS-1:0]     lane_im_q [P_FACTOR];
  logic signed [MULT_BITS_OUT-1:0] sum_re_c, sum_im_c;
  logic signed [MULT_BITS_OUT-1:0] sum_re_q, sum_im_q;

  // Lane products: re = ar*br + ai*bi, im = ai*br - ar*bi.
  always_comb begin
    for (int i = 0; i < P_FACTOR; i++) begin
      lane_re_c[i] = part(a_mul, i, 1'b0) * part(b_mul, i, 1'b0)
                   + part(a_mul, i, 1'b1) * part(b_mul, i, 1'b1);
      lane_im_c[i] = part(a_mul, i, 1'b1) * part(b_mul, i, 1'b0)
                   - part(a_mul, i, 1'b0) * part(b_mul, i, 1'b1);
    end
  end

  // Lane adder: sign-extend each lane product and sum to MULT_BITS_OUT.
  // NOTE: combinational outputs get a default before the loop, so no latch can form.
  always_comb begin
    sum_re_c = '0;
    sum_im_c = '0;
    for (int i = 0; i < P_FACTOR; i++) begin
      sum_re_c = sum_re_c + MULT_BITS_OUT'(lane_re_q[i]);
      sum_im_c = sum_im_c + MULT_BITS_OUT'(lane_im_q[i]);
    end
  end

  // Multiplier output register and lane-sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P_FACTOR; i++) begin
        lane_re_q[i] <= '0;
        lane_im_q[i] <= '0;
      end
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      for (int i = 0; i < P_FACTOR; i++) begin
        lane_re_q[i] <= lane_re_c[i];
        lane_im_q[i] <= lane_im_c[i];
      end
      sum_re_q <= sum_re_c;
      sum_im_q <= sum_im_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Tail delay that stands in for the later multipliers in the DSP adder chain.
  // It keeps the product latency at MULT_LATENCY for any P_FACTOR.
  // ---------------------------------------------------------------------------
  logic signed [MULT_BITS_OUT-1:0] prod_re, prod_im;

  generate
    if (TAIL_DEPTH == 0) begin : g_no_tail
      assign prod_re = sum_re_q;
      assign prod_im = sum_im_q;
    end else begin : g_tail
      logic signed [MULT_BITS_OUT-1:0] tail_re [TAIL_DEPTH];
      logic signed [MULT_BITS_OUT-1:0] tail_im [TAIL_DEPTH];

      // Tail shift register for the summed product.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < TAIL_DEPTH; i++) begin
            tail_re[i] <= '0;
            tail_im[i] <= '0;
          end
        end else begin
          tail_re[0] <= sum_re_q;
          tail_im[0] <= sum_im_q;
          for (int i = 1; i < TAIL_DEPTH; i++) begin
            tail_re[i] <= tail_re[i-1];
            tail_im[i] <= tail_im[i-1];
          end
        end
      end

      assign prod_re = tail_re[TAIL_DEPTH-1];
      assign prod_im = tail_im[TAIL_DEPTH-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Phase delay line: "index 0" flag travels alongside the product
  // ---------------------------------------------------------------------------
  logic [MULT_LATENCY-1:0] phase_sr;
  logic                    first_of_window;

  // Phase shift register, depth MULT_LATENCY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_sr <= '0;
    else     phase_sr <= {phase_sr[MULT_LATENCY-2:0], (win_cnt == '0)};
  end

  assign first_of_window = phase_sr[MULT_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Accumulator and dump strobe
  // ---------------------------------------------------------------------------
  logic signed [ACC_BITS_OUT-1:0] acc_re, acc_im;
  logic [2*ACC_BITS_OUT-1:0]      dump_data;
  logic                           dump_valid;

  // Accumulate: an index-0 product restarts the sum and dumps the old total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re     <= '0;
      acc_im     <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
    end else if (first_of_window) begin
      acc_re     <= ACC_BITS_OUT'(prod_re);
      acc_im     <= ACC_BITS_OUT'(prod_im);
      dump_data  <= {acc_re, acc_im};
      dump_valid <= 1'b1;
    end else begin
      acc_re     <= acc_re + ACC_BITS_OUT'(prod_re);
      acc_im     <= acc_im + ACC_BITS_OUT'(prod_im);
      dump_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output chain mux: the local dump wins over upstream data
  // ---------------------------------------------------------------------------
  logic [2*ACC_BITS_OUT-1:0] mux_data [ACC_MUX_LATENCY];
  logic [ACC_MUX_LATENCY-1:0] mux_valid;

  // Mux select plus ACC_MUX_LATENCY register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ACC_MUX_LATENCY; i++) mux_data[i] <= '0;
      mux_valid <= '0;
    end else begin
      mux_data[0]  <= dump_valid ? dump_data : acc_in;
      mux_valid[0] <= dump_valid | valid_in;
      for (int i = 1; i < ACC_MUX_LATENCY; i++) begin
        mux_data[i]  <= mux_data[i-1];
        mux_valid[i] <= mux_valid[i-1];
      end
    end
  end

  assign acc_out   = mux_data[ACC_MUX_LATENCY-1];
  assign valid_out = mux_valid[ACC_MUX_LATENCY-1];

`ifdef CMAC_SYNC_OUT_EN
  localparam int SYNC_DELAY = MULT_LATENCY + 1 + ACC_MUX_LATENCY + 1;
  logic [SYNC_DELAY-1:0] sync_sr;

  // Sync delay line that lines sync up with the acc_out window boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_sr <= '0;
    else     sync_sr <= {sync_sr[SYNC_DELAY-2:0], sync};
  end

  assign sync_out = sync_sr[SYNC_DELAY-1];
`endif

endmodule

// File: tb/tb_xeng_cmac.sv
// tb_xeng_cmac: directed and random stimulus for xeng_cmac. The outputs are
// compared every cycle with a window-level reference model. A second instance
// with P_FACTOR_BITS=1 is checked against the closed-form window totals.
module tb_xeng_cmac;

  localparam int BW   = 4;
  localparam int NWIN = 128;
  localparam int MUXL = 2;
  localparam int ML1  = 0 * 2 + 2 + 2;           // P_FACTOR = 1
  localparam int ML2  = 1 * 2 + 2 + 2;           // P_FACTOR = 2
  localparam int DL1  = ML1 + MUXL + 1;          // index-0 input cycle -> dump on acc_out
  localparam int DL2  = ML2 + MUXL + 1;
  localparam int AW1  = 2 * BW + 1 + 0 + 7;      // 16
  localparam int AW2  = 2 * BW + 1 + 1 + 7;      // 17
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst, sync, valid_in;
  logic [2*BW-1:0]  a, b;
  logic [2*AW1-1:0] acc_in, acc_out;
  logic             valid_out;

  logic [4*BW-1:0]  a2, b2;
  logic [2*AW2-1:0] acc_in2, acc_out2;
  logic             valid_out2;
`ifdef CMAC_SYNC_OUT_EN
  logic sync_out, sync_out2;
`endif

  always #5 clk = ~clk;

  xeng_cmac u_dut (
    .clk(clk), .rst(rst), .sync(sync), .a(a), .b(b),
    .acc_in(acc_in), .valid_in(valid_in), .acc_out(acc_out), .valid_out(valid_out)
`ifdef CMAC_SYNC_OUT_EN
    , .sync_out(sync_out)
`endif
  );

  xeng_cmac #(.P_FACTOR_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .sync(1'b0), .a(a2), .b(b2),
    .acc_in(acc_in2), .valid_in(1'b0), .acc_out(acc_out2), .valid_out(valid_out2)
`ifdef CMAC_SYNC_OUT_EN
    , .sync_out(sync_out2)
`endif
  );

  int nvec, nerr;
  int cyc, cnt, tot_re, tot_im;
  bit             exp_v   [MAXC];
  logic [2*AW1-1:0] exp_d [MAXC];
  bit             dump_at [MAXC];
  bit             sync_h  [MAXC];
  bit             pin_on  [MAXC];
  bit             pin_v   [MAXC];
  logic [2*AW1-1:0] pin_d [MAXC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nerr++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int s4(input logic [3:0] x);
    logic signed [3:0] t;
    t = x;
    return int'(t);
  endfunction

  task automatic model_reset();
    cyc = 0; cnt = 0; tot_re = 0; tot_im = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = 0; exp_d[i] = '0; dump_at[i] = 0; sync_h[i] = 0;
      pin_on[i] = 0; pin_v[i] = 0; pin_d[i] = '0;
    end
  endtask

  task automatic pin(input int c, input bit v, input logic [2*AW1-1:0] d);
    pin_on[c] = 1; pin_v[c] = v; pin_d[c] = d;
  endtask

  // Window-level reference: a complex MAC over the current window. An index-0
  // sample closes the previous window and schedules its total DL1 cycles later.
  // Cycles without a dump pass acc_in/valid_in through after MUXL cycles.
  task automatic model_step();
    int ar, ai, br, bi, pr, pim;
    if (cyc + DL1 >= MAXC) begin
      $display("FAIL model_range: cycle %0d exceeds table size %0d", cyc, MAXC);
      $fatal(1);
    end
    ar = s4(a[7:4]); ai = s4(a[3:0]); br = s4(b[7:4]); bi = s4(b[3:0]);
    pr  = ar * br + ai * bi;
    pim = ai * br - ar * bi;
    if (cnt == 0) begin
      dump_at[cyc+DL1] = 1;
      exp_v[cyc+DL1]   = 1;
      exp_d[cyc+DL1]   = {tot_re[AW1-1:0], tot_im[AW1-1:0]};
      tot_re = pr; tot_im = pim;
    end else begin
      tot_re += pr; tot_im += pim;
    end
    if (!dump_at[cyc+MUXL]) begin
      exp_v[cyc+MUXL] = valid_in;
      exp_d[cyc+MUXL] = acc_in;
    end
    sync_h[cyc] = sync;
    cnt = sync ? 0 : (cnt + 1) % NWIN;
  endtask

  task automatic tick();
    int  j;
    bit  v2;
    logic [2*AW2-1:0] d2;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("valid_out", 64'(valid_out), 64'(exp_v[cyc]));
    check("acc_out", 64'(acc_out), 64'(exp_d[cyc]));
    if (pin_on[cyc]) begin
      check("pin_valid", 64'(valid_out), 64'(pin_v[cyc]));
      check("pin_data", 64'(acc_out), 64'(pin_d[cyc]));
    end
    // Second instance: constant 2-lane 1+1j samples, no sync, 512 per full window.
    j  = cyc - DL2;
    v2 = (j >= 0) && (j % NWIN == 0);
    d2 = (v2 && j >= NWIN) ? {17'd512, 17'd0} : '0;
    check("p2_valid_out", 64'(valid_out2), 64'(v2));
    check("p2_acc_out", 64'(acc_out2), 64'(d2));
`ifdef CMAC_SYNC_OUT_EN
    check("sync_out", 64'(sync_out), 64'((cyc >= DL1 + 1) ? sync_h[cyc-DL1-1] : 1'b0));
    check("p2_sync_out", 64'(sync_out2), 64'(0));
`endif
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1; sync = 1'b0; a = '0; b = '0; acc_in = '0; valid_in = 1'b0;
    a2 = 16'h1111; b2 = 16'h1111; acc_in2 = '0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc_out", 64'(acc_out), 64'(0));
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_p2_acc_out", 64'(acc_out2), 64'(0));
    check("rst_p2_valid_out", 64'(valid_out2), 64'(0));
    rst = 1'b0;
    model_reset();

    // Spec-derived window totals at their documented output cycles.
    pin(DL1, 1, '0);                                  // first dump: nothing accumulated
    pin(NWIN + DL1, 1, {16'd448, 16'd0});
    pin(2*NWIN + DL1, 1, {16'd448, 16'd0});
    pin(3*NWIN + DL1, 1, {16'd448, 16'd0});
    pin(3*NWIN + DL1 - 1, 0, '0);
    pin(3*NWIN + DL1 + 1, 0, '0);
    pin(4*NWIN + DL1, 1, {16'd16384, 16'd0});
    pin(5*NWIN + DL1, 1, {16'd16384, 16'd0});
    pin(651, 0, '0);
    pin(652, 1, 32'h12345678);
    pin(653, 0, '0);
    pin(701 + DL1 - 1, 0, '0);
    pin(701 + DL1, 1, {16'd80, 16'd0});              // truncated 40-sample window
    pin(701 + DL1 + 1, 0, '0);
    pin(701 + NWIN + DL1, 1, {16'd256, 16'd0});      // fresh window after the new sync

    // a = 0+1j, b imag cycles 0..7, sync every 128 cycles (cycles 0..383).
    a = 8'h01;
    for (int i = 0; i < 3 * NWIN; i++) begin
      b    = {5'b0, 3'(i)};
      sync = (i % NWIN == NWIN - 1);
      tick();
    end

    // a = b = -8-8j for two full windows (cycles 384..639).
    sync = 1'b0; a = 8'h88; b = 8'h88;
    repeat (2 * NWIN) tick();

    // Pass-through of one upstream word (cycles 640..659, word at 650).
    a = '0; b = '0;
    for (int i = 0; i < 20; i++) begin
      valid_in = (i == 10);
      acc_in   = (i == 10) ? 32'h12345678 : 32'h0;
      tick();
    end

    // Sync at 660, second sync 40 samples into the new window (cycle 700).
    a = 8'h11; b = 8'h11;
    for (int i = 0; i < 180; i++) begin
      sync = (i == 0) || (i == 40);
      tick();
    end

    // Random samples, chain traffic and occasional sync.
    for (int i = 0; i < 400; i++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      acc_in   = 32'($urandom);
      valid_in = ($urandom_range(7) == 0);
      sync     = ($urandom_range(63) == 0);
      tick();
    end
    valid_in = 1'b0; sync = 1'b0; acc_in = '0;
    repeat (20) tick();

    // Asynchronous reset in the middle of a window, with live chain data.
    valid_in = 1'b1; acc_in = 32'hA5A50001;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    check("async_rst_acc_out", 64'(acc_out), 64'(0));
    check("async_rst_valid_out", 64'(valid_out), 64'(0));
    check("async_rst_p2_acc_out", 64'(acc_out2), 64'(0));
    check("async_rst_p2_valid_out", 64'(valid_out2), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; valid_in = 1'b0; acc_in = '0; sync = 1'b0;
    a = 8'h11; b = 8'h11;
    model_reset();
    pin(DL1, 1, '0);
    pin(NWIN + DL1, 1, {16'd256, 16'd0});
    repeat (300) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
